coin_scan_renderer: RTL and testbench
=====================================

Name: coin_scan_renderer

Overview:
- Consumes the coin position table and the per-coin visibility flags produced by the collision checkers.
- Answers "which coin, if any, covers this pixel" for the VGA scan, with fixed latency, so the colour mux can fetch coin sprite texels.
- Snapshots coin state once per frame to prevent tearing.
- Tracks collected coins for the score/level-clear logic.

Parameters:
- N_COINS, 4, number of coin slots (indices 0..N_COINS-1).
- COIN_SIZE, 16, coin sprite edge length in pixels; coin covers left_x..left_x+COIN_SIZE-1, top_y..top_y+COIN_SIZE-1 inclusive.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- frame_start  input  1  one-cycle pulse at start of vertical blank.
- pix_valid  input  1  pix_x/pix_y carry an active-area pixel this cycle.
- pix_x  input  10  scan column, 0..639.
- pix_y  input  9  scan row, 0..479.
- coin_left_x  input  N_COINS x 10  coin left edges.
- coin_top_y  input  N_COINS x 9  coin top edges.
- coin_vis  input  N_COINS  live visibility flags, 1 = coin present.
- out_valid  output  1  pipelined pix_valid.
- coin_hit  output  1  pixel lies inside a visible snapshot coin.
- coin_idx  output  2  index of the hit coin (lowest index wins); 0 when no hit.
- tex_col  output  4  pix_x - left_x of the hit coin; 0 when no hit.
- tex_row  output  4  pix_y - top_y of the hit coin; 0 when no hit.
- collected_count  output  3  coins collected since reset, saturating at N_COINS.
- all_collected  output  1  collected_count == N_COINS.
- armed  output  1  at least one snapshot taken since reset.

Behaviour:
- Reset (synchronous, active-high; clk rising edge): all outputs 0.
  - Snapshot visibility cleared to 0; snapshot positions cleared to 0.
  - Pipeline valid bits cleared; prev_vis register cleared to 0.
  - FSM enters S_WAIT_FRAME.
  - A reset mid-frame discards in-flight pixels; out_valid is 0 the following cycle.
- FSM:
  - S_WAIT_FRAME: armed=0; coin_hit is forced 0. On sampled frame_start: load snapshot, go to S_ACTIVE.
  - S_ACTIVE: armed=1. Every sampled frame_start reloads coin_left_x/coin_top_y/coin_vis into the snapshot. Stays in S_ACTIVE until reset.
- Snapshot timing: the snapshot register updates on the edge where frame_start is sampled high. Live changes to coin_vis within a frame do not affect rendering until the next frame_start.
- Pipeline, latency 2:
  - Edge k: stage 1 captures pix_valid/pix_x/pix_y.
  - During cycle k..k+1: the per-coin compare uses stage-1 values and the current snapshot.
  - Edge k+1: stage 2 registers the results; the outputs are stage 2.
  - A pixel sampled on the same edge as frame_start is therefore compared against the new snapshot.
  - One pixel per cycle, no stalls; pix_valid=0 bubbles propagate as out_valid=0 with hit/idx/tex = 0.
- Hit test:
  - Coin i hits when snapshot vis[i]=1 AND pix_x >= x_i AND pix_x <= x_i+COIN_SIZE-1 AND pix_y >= y_i AND pix_y <= y_i+COIN_SIZE-1.
  - Sums computed at 11/10 bits so that no wrap occurs: coin at x=630 covers 630..645 and matches 630..639 only.
  - Multiple hits: lowest index selected. tex_col/tex_row are the low 4 bits of the differences for the selected coin.
- Collection counter:
  - Each cycle (in either FSM state), fall[i] = prev_vis[i] & ~coin_vis[i]; prev_vis <= coin_vis.
  - collected_count += popcount(fall), saturating at N_COINS.
  - Rising edges (respawn) never decrement.
  - Live coin_vis is used, not the snapshot.
  - all_collected is registered, combinationally derived from the registered count (same cycle as count).
- Simultaneous frame_start and falls: both take effect on the same edge, independently.

Test Plan:
- Reset, coin_vis=4'b1111, coin0 at (100,50), no frame_start; drive pixel (100,50) -> out_valid=1 two cycles later, coin_hit=0, armed=0.
- Pulse frame_start, then pixel (107,60) -> 2 cycles later coin_hit=1, coin_idx=0, tex_col=7, tex_row=10. Pixel (116,50) -> coin_hit=0.
- Overlap: coin1 and coin2 both at (200,200), vis all 1, frame_start, pixel (205,205) -> coin_idx=1.
- Snapshot hold:
  - After frame_start, drop coin_vis[0] mid-frame; pixel (100,50) -> still hit=1.
  - Pulse frame_start again; same pixel -> hit=0.
- Collection:
  - Drop coin_vis bits 0 and 3 on the same cycle -> collected_count=2 next cycle.
  - Raise bit 0 and drop it again -> 3. Drop bits 1,2 -> 4 with all_collected=1.
  - Further falls after respawn -> count stays 4.
- Edge/reset: coin at (630,470), pixel (639,479) -> hit=1, tex_col=9, tex_row=9. Assert reset with valid pixels in flight -> next cycle out_valid=0, count=0, armed=0.

Source files
------------

// File: rtl/coin_scan_renderer.sv
// rtl/coin_scan_renderer.sv - fixed-latency coin lookup for the VGA scan
// Coin state is snapshotted on frame_start; collection counting uses live visibility.
module coin_scan_renderer #(
  parameter int N_COINS   = 4,
  parameter int COIN_SIZE = 16,
  localparam int IW = (N_COINS > 1) ? $clog2(N_COINS) : 1,
  localparam int CW = $clog2(N_COINS + 1),
  localparam int TW = $clog2(COIN_SIZE)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic                     pix_valid,
  input  logic [9:0]               pix_x,
  input  logic [8:0]               pix_y,
  input  logic [N_COINS-1:0][9:0]  coin_left_x,
  input  logic [N_COINS-1:0][8:0]  coin_top_y,
  input  logic [N_COINS-1:0]       coin_vis,
  output logic                     out_valid,
  output logic                     coin_hit,
  output logic [IW-1:0]            coin_idx,
  output logic [TW-1:0]            tex_col,
  output logic [TW-1:0]            tex_row,
  output logic [CW-1:0]            collected_count,
  output logic                     all_collected,
  output logic                     armed
);

  typedef enum logic {S_WAIT_FRAME, S_ACTIVE} state_t;

  // Spans are one bit wider than the coordinates so x=630 covers 630..645 without wrapping.
  localparam logic [10:0] X_SPAN = 11'(COIN_SIZE - 1);
  localparam logic [9:0]  Y_SPAN = 10'(COIN_SIZE - 1);

  state_t                    state_q, state_d;
  logic [N_COINS-1:0][9:0]   snap_x_q, snap_x_d;
  logic [N_COINS-1:0][8:0]   snap_y_q, snap_y_d;
  logic [N_COINS-1:0]        snap_v_q, snap_v_d;
  logic [N_COINS-1:0]        prev_vis_q, prev_vis_d;
  logic [CW-1:0]             count_q, count_d;
  logic                      all_q, all_d;
  logic                      s1_valid_q, s1_valid_d;
  logic [9:0]                s1_x_q, s1_x_d;
  logic [8:0]                s1_y_q, s1_y_d;
  logic                      s2_valid_q, s2_valid_d;
  logic                      s2_hit_q, s2_hit_d;
  logic [IW-1:0]             s2_idx_q, s2_idx_d;
  logic [TW-1:0]             s2_col_q, s2_col_d;
  logic [TW-1:0]             s2_row_q, s2_row_d;
  logic [CW-1:0]             fall_cnt;
  logic [CW:0]               sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT_FRAME;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_WAIT_FRAME && frame_start) begin
      state_d = S_ACTIVE;
    end
  end

  always_comb begin
    armed = (state_q == S_ACTIVE);
  end

  always_comb begin
    snap_x_d   = snap_x_q;
    snap_y_d   = snap_y_q;
    snap_v_d   = snap_v_q;
    if (frame_start) begin
      snap_x_d = coin_left_x;
      snap_y_d = coin_top_y;
      snap_v_d = coin_vis;
    end
    s1_valid_d = pix_valid;
    s1_x_d     = pix_x;
    s1_y_d     = pix_y;
  end

  // Scan from the highest index down so the lowest matching coin is the last one written.
  always_comb begin
    s2_valid_d = s1_valid_q;
    s2_hit_d   = 1'b0;
    s2_idx_d   = '0;
    s2_col_d   = '0;
    s2_row_d   = '0;
    for (int i = N_COINS - 1; i >= 0; i--) begin
      if (s1_valid_q && armed && snap_v_q[i]
          && s1_x_q >= snap_x_q[i] && {1'b0, s1_x_q} <= {1'b0, snap_x_q[i]} + X_SPAN
          && s1_y_q >= snap_y_q[i] && {1'b0, s1_y_q} <= {1'b0, snap_y_q[i]} + Y_SPAN) begin
        s2_hit_d = 1'b1;
        s2_idx_d = IW'(i);
        s2_col_d = TW'(s1_x_q - snap_x_q[i]);
        s2_row_d = TW'(s1_y_q - snap_y_q[i]);
      end
    end
  end

  always_comb begin
    fall_cnt = '0;
    for (int i = 0; i < N_COINS; i++) begin
      fall_cnt = fall_cnt + CW'(prev_vis_q[i] & ~coin_vis[i]);
    end
    sum        = {1'b0, count_q} + {1'b0, fall_cnt};
    count_d    = (sum > (CW + 1)'(N_COINS)) ? CW'(N_COINS) : sum[CW-1:0];
    all_d      = (count_d == CW'(N_COINS));
    prev_vis_d = coin_vis;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      snap_x_q   <= '0;
      snap_y_q   <= '0;
      snap_v_q   <= '0;
      prev_vis_q <= '0;
      count_q    <= '0;
      all_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_hit_q   <= 1'b0;
      s2_idx_q   <= '0;
      s2_col_q   <= '0;
      s2_row_q   <= '0;
    end else begin
      snap_x_q   <= snap_x_d;
      snap_y_q   <= snap_y_d;
      snap_v_q   <= snap_v_d;
      prev_vis_q <= prev_vis_d;
      count_q    <= count_d;
      all_q      <= all_d;
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s2_valid_q <= s2_valid_d;
      s2_hit_q   <= s2_hit_d;
      s2_idx_q   <= s2_idx_d;
      s2_col_q   <= s2_col_d;
      s2_row_q   <= s2_row_d;
    end
  end

  assign out_valid       = s2_valid_q;
  assign coin_hit        = s2_hit_q;
  assign coin_idx        = s2_idx_q;
  assign tex_col         = s2_col_q;
  assign tex_row         = s2_row_q;
  assign collected_count = count_q;
  assign all_collected   = all_q;

endmodule

// File: tb/tb_coin_scan_renderer.sv
// tb/tb_coin_scan_renderer.sv - self-checking bench for coin_scan_renderer
module tb_coin_scan_renderer;
  localparam int N = 4;

  logic              clk = 1'b0;
  logic              reset, frame_start, pix_valid;
  logic [9:0]        pix_x;
  logic [8:0]        pix_y;
  logic [N-1:0][9:0] coin_left_x;
  logic [N-1:0][8:0] coin_top_y;
  logic [N-1:0]      coin_vis;
  logic              out_valid, coin_hit, all_collected, armed;
  logic [1:0]        coin_idx;
  logic [3:0]        tex_col, tex_row;
  logic [2:0]        collected_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       v;
    logic       hit;
    logic [1:0] idx;
    logic [3:0] col;
    logic [3:0] row;
  } pix_t;

  int     snap_x [N];
  int     snap_y [N];
  bit     snap_v [N];
  bit     m_armed;
  int     m_count;
  logic [N-1:0] m_prev;
  pix_t   m_s1, m_out;

  coin_scan_renderer #(.N_COINS(N), .COIN_SIZE(16)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .coin_left_x(coin_left_x), .coin_top_y(coin_top_y),
    .coin_vis(coin_vis), .out_valid(out_valid), .coin_hit(coin_hit), .coin_idx(coin_idx),
    .tex_col(tex_col), .tex_row(tex_row), .collected_count(collected_count),
    .all_collected(all_collected), .armed(armed)
  );

  always #5 clk = ~clk;

  function automatic pix_t ref_pixel(bit v, int px, int py);
    pix_t r;
    r = '0;
    r.v = v;
    if (!v || !m_armed) return r;
    for (int i = 0; i < N; i++) begin
      if (snap_v[i] && px >= snap_x[i] && px < snap_x[i] + 16 &&
          py >= snap_y[i] && py < snap_y[i] + 16) begin
        r.hit = 1'b1;
        r.idx = 2'(i);
        r.col = 4'(px - snap_x[i]);
        r.row = 4'(py - snap_y[i]);
        return r;
      end
    end
    return r;
  endfunction

  // Advance the reference model with what the DUT samples on the coming edge, then clock.
  task automatic tick();
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        snap_x[i] = 0; snap_y[i] = 0; snap_v[i] = 0;
      end
      m_armed = 0; m_count = 0; m_prev = '0; m_s1 = '0; m_out = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_prev[i] && !coin_vis[i]) m_count++;
      end
      if (m_count > N) m_count = N;
      m_prev = coin_vis;
      if (frame_start) begin
        for (int i = 0; i < N; i++) begin
          snap_x[i] = int'(coin_left_x[i]);
          snap_y[i] = int'(coin_top_y[i]);
          snap_v[i] = coin_vis[i];
        end
        m_armed = 1;
      end
      m_out = m_s1;
      m_s1  = ref_pixel(pix_valid, int'(pix_x), int'(pix_y));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Drive one pixel then a bubble; outputs then show that pixel.
  task automatic send_pixel(int px, int py);
    pix_valid = 1'b1; pix_x = 10'(px); pix_y = 9'(py);
    tick();
    pix_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    frame_start = 0; pix_valid = 0; pix_x = 0; pix_y = 0;
    coin_vis = 4'b1111;
    coin_left_x[0] = 10'd100; coin_top_y[0] = 9'd50;
    coin_left_x[1] = 10'd400; coin_top_y[1] = 9'd400;
    coin_left_x[2] = 10'd450; coin_top_y[2] = 9'd400;
    coin_left_x[3] = 10'd500; coin_top_y[3] = 9'd400;
    do_reset();
    checks++;
    if ({out_valid, coin_hit, coin_idx, tex_col, tex_row, collected_count, all_collected, armed} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b hit=%b idx=%0d col=%0d row=%0d cnt=%0d all=%b armed=%b, want all 0",
               out_valid, coin_hit, coin_idx, tex_col, tex_row, collected_count, all_collected, armed);
    end
    send_pixel(100, 50);
    checks++;
    if (out_valid !== 1'b1 || coin_hit !== 1'b0 || armed !== 1'b0) begin
      errors++;
      $display("FAIL unarmed_pixel: got valid=%b hit=%b armed=%b, want 1 0 0", out_valid, coin_hit, armed);
    end
  endtask

  task automatic test_basic_hit();
    pulse_frame();
    send_pixel(107, 60);
    checks++;
    if (out_valid !== 1'b1 || coin_hit !== 1'b1 || coin_idx !== 2'd0 || tex_col !== 4'd7 ||
        tex_row !== 4'd10 || armed !== 1'b1) begin
      errors++;
      $display("FAIL basic_hit: got valid=%b hit=%b idx=%0d col=%0d row=%0d armed=%b, want 1 1 0 7 10 1",
               out_valid, coin_hit, coin_idx, tex_col, tex_row, armed);
    end
    send_pixel(116, 50);
    checks++;
    if (out_valid !== 1'b1 || coin_hit !== 1'b0 || coin_idx !== 2'd0 || tex_col !== 4'd0 || tex_row !== 4'd0) begin
      errors++;
      $display("FAIL right_edge_miss: got valid=%b hit=%b idx=%0d col=%0d row=%0d, want 1 0 0 0 0",
               out_valid, coin_hit, coin_idx, tex_col, tex_row);
    end
  endtask

  task automatic test_overlap();
    coin_left_x[1] = 10'd200; coin_top_y[1] = 9'd200;
    coin_left_x[2] = 10'd200; coin_top_y[2] = 9'd200;
    pulse_frame();
    send_pixel(205, 205);
    checks++;
    if (coin_hit !== 1'b1 || coin_idx !== 2'd1 || tex_col !== 4'd5 || tex_row !== 4'd5) begin
      errors++;
      $display("FAIL overlap_priority: got hit=%b idx=%0d col=%0d row=%0d, want 1 1 5 5",
               coin_hit, coin_idx, tex_col, tex_row);
    end
  endtask

  task automatic test_snapshot_hold();
    coin_vis[0] = 1'b0;
    tick();
    send_pixel(100, 50);
    checks++;
    if (coin_hit !== 1'b1 || coin_idx !== 2'd0) begin
      errors++;
      $display("FAIL snapshot_hold: got hit=%b idx=%0d, want 1 0", coin_hit, coin_idx);
    end
    pulse_frame();
    send_pixel(100, 50);
    checks++;
    if (coin_hit !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL snapshot_reload: got hit=%b valid=%b, want 0 1", coin_hit, out_valid);
    end
  endtask

  task automatic test_collection();
    coin_vis = 4'b1111;
    do_reset();
    tick();
    coin_vis = 4'b0110;
    tick();
    checks++;
    if (collected_count !== 3'd2 || all_collected !== 1'b0) begin
      errors++;
      $display("FAIL collect_two: got cnt=%0d all=%b, want 2 0", collected_count, all_collected);
    end
    coin_vis[0] = 1'b1;
    tick();
    checks++;
    if (collected_count !== 3'd2) begin
      errors++;
      $display("FAIL respawn_no_dec: got cnt=%0d, want 2", collected_count);
    end
    coin_vis[0] = 1'b0;
    tick();
    checks++;
    if (collected_count !== 3'd3) begin
      errors++;
      $display("FAIL collect_three: got cnt=%0d, want 3", collected_count);
    end
    coin_vis = 4'b0000;
    tick();
    checks++;
    if (collected_count !== 3'd4 || all_collected !== 1'b1) begin
      errors++;
      $display("FAIL collect_all: got cnt=%0d all=%b, want 4 1", collected_count, all_collected);
    end
    coin_vis = 4'b1111;
    tick();
    coin_vis = 4'b0000;
    tick();
    checks++;
    if (collected_count !== 3'd4 || all_collected !== 1'b1) begin
      errors++;
      $display("FAIL saturate: got cnt=%0d all=%b, want 4 1", collected_count, all_collected);
    end
  endtask

  task automatic test_edge_and_reset();
    coin_vis = 4'b1111;
    coin_left_x[0] = 10'd630; coin_top_y[0] = 9'd470;
    pulse_frame();
    send_pixel(639, 479);
    checks++;
    if (coin_hit !== 1'b1 || coin_idx !== 2'd0 || tex_col !== 4'd9 || tex_row !== 4'd9) begin
      errors++;
      $display("FAIL screen_corner: got hit=%b idx=%0d col=%0d row=%0d, want 1 0 9 9",
               coin_hit, coin_idx, tex_col, tex_row);
    end
    send_pixel(629, 470);
    checks++;
    if (coin_hit !== 1'b0) begin
      errors++;
      $display("FAIL left_of_coin: got hit=%b, want 0", coin_hit);
    end
    coin_vis = 4'b0000;
    tick();
    pix_valid = 1'b1; pix_x = 10'd635; pix_y = 9'd475;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || coin_hit !== 1'b0 || collected_count !== 3'd0 || armed !== 1'b0 ||
        all_collected !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_flight: got valid=%b hit=%b cnt=%0d armed=%b all=%b, want all 0",
               out_valid, coin_hit, collected_count, armed, all_collected);
    end
    pix_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_random();
    int j, px, py;
    coin_vis = 4'b1111;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        j = $urandom_range(0, N - 1);
        coin_left_x[j] = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(620, 639)) : 10'($urandom_range(0, 639));
        coin_top_y[j]  = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(460, 479)) : 9'($urandom_range(0, 479));
      end
      if ($urandom_range(0, 9) == 0) coin_vis[$urandom_range(0, N - 1)] ^= 1'b1;
      frame_start = ($urandom_range(0, 19) == 0);
      pix_valid   = ($urandom_range(0, 4) != 0);
      j  = $urandom_range(0, N - 1);
      px = int'(coin_left_x[j]) + $urandom_range(0, 19) - 2;
      py = int'(coin_top_y[j]) + $urandom_range(0, 19) - 2;
      if ($urandom_range(0, 3) == 0) begin
        px = $urandom_range(0, 639);
        py = $urandom_range(0, 479);
      end
      px = (px < 0) ? 0 : (px > 639 ? 639 : px);
      py = (py < 0) ? 0 : (py > 479 ? 479 : py);
      pix_x = 10'(px);
      pix_y = 9'(py);
      tick();
      checks++;
      if ({out_valid, coin_hit, coin_idx, tex_col, tex_row} !== m_out ||
          int'(collected_count) != m_count || all_collected !== (m_count == N) || armed !== m_armed) begin
        errors++;
        $display("FAIL random_cycle_%0d: got v=%b h=%b i=%0d c=%0d r=%0d cnt=%0d all=%b arm=%b, want v=%b h=%b i=%0d c=%0d r=%0d cnt=%0d all=%b arm=%b",
                 c, out_valid, coin_hit, coin_idx, tex_col, tex_row, collected_count, all_collected, armed,
                 m_out.v, m_out.hit, m_out.idx, m_out.col, m_out.row, m_count, (m_count == N), m_armed);
      end
    end
    frame_start = 1'b0;
    pix_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_basic_hit();
    test_overlap();
    test_snapshot_hold();
    test_collection();
    test_edge_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
